// File: rtl/fibo_sched_pkg.sv
// fibo_sched_pkg: shared state encoding and default widths for the Fibonacci scheduler.
`default_nettype none

package fibo_sched_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int CNT_W_DEF  = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_GAP  = 2'd2
    } state_e;

endpackage

`default_nettype wire

// File: rtl/fibo_core.sv
// fibo_core: Fibonacci term pair (a, b) with load, step and saturation tracking.
`default_nettype none

module fibo_core #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic              step_i,
    output logic [DATA_W-1:0] a_o,
    output logic              ovf_o
);

    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic              bsat_q;
    logic              ovf_q;
    logic [DATA_W:0]   sum_w;

    assign sum_w = {1'b0, a_q} + {1'b0, b_q};

    // bsat_q marks a b that was clamped; ovf rises once that b moves into a.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_q    <= '0;
            b_q    <= DATA_W'(1);
            bsat_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (load_i) begin
            a_q    <= '0;
            b_q    <= DATA_W'(1);
            bsat_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (step_i) begin
            a_q    <= b_q;
            b_q    <= sum_w[DATA_W] ? '1 : sum_w[DATA_W-1:0];
            bsat_q <= sum_w[DATA_W];
            ovf_q  <= ovf_q | bsat_q;
        end
    end

    assign a_o   = a_q;
    assign ovf_o = ovf_q;

endmodule

`default_nettype wire

// File: rtl/fibo_sched.sv
// fibo_sched: round-robin arbiter between two requesters, streaming a Fibonacci
// sequence of the granted length with ready/valid handshake.
`default_nettype none

module fibo_sched
    import fibo_sched_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        req,
    input  logic [CNT_W-1:0]  len0,
    input  logic [CNT_W-1:0]  len1,
    output logic [1:0]        gnt,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_id,
    output logic              out_last,
    output logic              ovf,
    output logic              busy
);

    localparam logic [CNT_W:0] CNT_ONE = {{CNT_W{1'b0}}, 1'b1};

    state_e            state_q, state_d;
    logic              ptr_q, ptr_d;
    logic              id_q, id_d;
    logic [CNT_W:0]    cnt_q, cnt_d;

    logic              winner_w;
    logic [CNT_W-1:0]  len_sel_w;
    logic [CNT_W:0]    cnt_load_w;
    logic              run_w;
    logic              xfer_w;
    logic              last_w;
    logic              load_w;
    logic              step_w;
    logic [DATA_W-1:0] a_w;
    logic              core_ovf_w;

    assign winner_w   = (req == 2'b11) ? ptr_q : req[1];
    assign len_sel_w  = winner_w ? len1 : len0;
    // A zero length encodes the full 2^CNT_W sequence, hence the extra count bit.
    assign cnt_load_w = (len_sel_w == '0) ? {1'b1, {CNT_W{1'b0}}} : {1'b0, len_sel_w};
    assign run_w      = (state_q == S_RUN);
    assign xfer_w     = run_w & out_ready;
    assign last_w     = run_w & (cnt_q == CNT_ONE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            ptr_q   <= 1'b0;
            id_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        id_d    = id_q;
        cnt_d   = cnt_q;
        load_w  = 1'b0;
        step_w  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (|req) begin
                    id_d    = winner_w;
                    cnt_d   = cnt_load_w;
                    load_w  = 1'b1;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (xfer_w) begin
                    cnt_d  = cnt_q - CNT_ONE;
                    step_w = 1'b1;
                end
                // Completion and abort both hand priority to the other requester.
                if ((xfer_w && last_w) || !req[id_q]) begin
                    ptr_d   = ~id_q;
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    fibo_core #(
        .DATA_W (DATA_W)
    ) u_core (
        .clk    (clk),
        .rst    (rst),
        .load_i (load_w),
        .step_i (step_w),
        .a_o    (a_w),
        .ovf_o  (core_ovf_w)
    );

    assign gnt       = run_w ? (id_q ? 2'b10 : 2'b01) : 2'b00;
    assign out_valid = run_w;
    assign out_data  = run_w ? a_w : '0;
    assign out_id    = id_q;
    assign out_last  = last_w;
    assign ovf       = run_w & core_ovf_w;
    assign busy      = (state_q != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_fibo_sched.sv
// tb_fibo_sched: directed scenario tests for fibo_sched with hand-computed terms.
`default_nettype none

module tb_fibo_sched;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] req;
    logic [3:0] len0;
    logic [3:0] len1;
    logic [1:0] gnt;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_id;
    logic       out_last;
    logic       ovf;
    logic       busy;

    int errors = 0;
    int checks = 0;

    logic [7:0] fib [16] = '{8'd0, 8'd1, 8'd1, 8'd2, 8'd3, 8'd5, 8'd8, 8'd13,
                             8'd21, 8'd34, 8'd55, 8'd89, 8'd144, 8'd233, 8'd255, 8'd255};

    always #5 clk = ~clk;

    fibo_sched #(.DATA_W(8), .CNT_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .len0      (len0),
        .len1      (len1),
        .gnt       (gnt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_id    (out_id),
        .out_last  (out_last),
        .ovf       (ovf),
        .busy      (busy)
    );

    task automatic test_reset;
        rst = 1'b0; req = 2'b00; len0 = '0; len1 = '0; out_ready = 1'b0;
        @(negedge clk);
        checks++;
        if ({gnt, out_valid, out_data, out_id, out_last, ovf, busy} !== 14'd0) begin
            errors++;
            $display("FAIL reset_outputs: got gnt=%b v=%b d=%0d id=%b last=%b ovf=%b busy=%b, want all 0",
                     gnt, out_valid, out_data, out_id, out_last, ovf, busy);
        end
        rst = 1'b1;
    endtask

    task automatic test_tie;
        req = 2'b11; len0 = 4'd3; len1 = 4'd2; out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (gnt !== 2'b01 || out_id !== 1'b0) begin
            errors++; $display("FAIL tie_first_gnt: got gnt=%b id=%b, want 01/0", gnt, out_id);
        end
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_data !== fib[i] || out_last !== (i == 2)) begin
                errors++; $display("FAIL tie_id0_beat%0d: got v=%b d=%0d last=%b, want 1/%0d/%b",
                                   i, out_valid, out_data, out_last, fib[i], (i == 2));
            end
        end
        @(negedge clk);
        checks++;
        if (gnt !== 2'b00 || out_valid !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL tie_gap: got gnt=%b v=%b busy=%b, want 00/0/1", gnt, out_valid, busy);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL tie_idle: got busy=%b, want 0", busy);
        end
        @(negedge clk);
        checks++;
        if (gnt !== 2'b10 || out_id !== 1'b1) begin
            errors++; $display("FAIL tie_second_gnt: got gnt=%b id=%b, want 10/1", gnt, out_id);
        end
        for (int i = 0; i < 2; i++) begin
            if (i > 0) @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_data !== fib[i] || out_last !== (i == 1)) begin
                errors++; $display("FAIL tie_id1_beat%0d: got v=%b d=%0d last=%b, want 1/%0d/%b",
                                   i, out_valid, out_data, out_last, fib[i], (i == 1));
            end
        end
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (gnt !== 2'b01) begin
            errors++; $display("FAIL tie_third_gnt: got gnt=%b, want 01", gnt);
        end
        // Drop on a transferring edge: beat counts, then abort.
        req = 2'b00;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b1 || out_last !== 1'b0) begin
            errors++; $display("FAIL tie_abort_gap: got v=%b busy=%b last=%b, want 0/1/0", out_valid, busy, out_last);
        end
        @(negedge clk);
    endtask

    task automatic test_single;
        req = 2'b01; len0 = 4'd5; out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (gnt !== 2'b01 || busy !== 1'b1) begin
            errors++; $display("FAIL single_gnt: got gnt=%b busy=%b, want 01/1", gnt, busy);
        end
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_data !== fib[i] || out_last !== (i == 4) || ovf !== 1'b0) begin
                errors++; $display("FAIL single_beat%0d: got v=%b d=%0d last=%b ovf=%b, want 1/%0d/%b/0",
                                   i, out_valid, out_data, out_last, ovf, fib[i], (i == 4));
            end
            if (i == 4) req = 2'b00;
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || gnt !== 2'b00 || busy !== 1'b1) begin
            errors++; $display("FAIL single_gap: got v=%b gnt=%b busy=%b, want 0/00/1", out_valid, gnt, busy);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL single_idle: got busy=%b v=%b, want 0/0", busy, out_valid);
        end
    endtask

    task automatic test_ovf;
        req = 2'b01; len0 = 4'd0; out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_data !== fib[i] || ovf !== (i >= 14) || out_last !== (i == 15)) begin
                errors++; $display("FAIL ovf_beat%0d: got v=%b d=%0d ovf=%b last=%b, want 1/%0d/%b/%b",
                                   i, out_valid, out_data, ovf, out_last, fib[i], (i >= 14), (i == 15));
            end
            if (i == 15) req = 2'b00;
        end
        @(negedge clk);
        checks++;
        if (ovf !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL ovf_gap: got ovf=%b v=%b busy=%b, want 0/0/1", ovf, out_valid, busy);
        end
        @(negedge clk);
    endtask

    task automatic test_abort;
        req = 2'b10; len1 = 4'd6; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (gnt !== 2'b10 || out_valid !== 1'b1 || out_data !== fib[i] || out_last !== 1'b0) begin
                errors++; $display("FAIL abort_beat%0d: got gnt=%b v=%b d=%0d last=%b, want 10/1/%0d/0",
                                   i, gnt, out_valid, out_data, out_last, fib[i]);
            end
        end
        req = 2'b00; out_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || out_last !== 1'b0 || gnt !== 2'b00 || busy !== 1'b1) begin
            errors++; $display("FAIL abort_gap: got v=%b last=%b gnt=%b busy=%b, want 0/0/00/1",
                               out_valid, out_last, gnt, busy);
        end
        @(negedge clk);
        req = 2'b11; len0 = 4'd2;
        @(negedge clk);
        checks++;
        if (gnt !== 2'b01) begin
            errors++; $display("FAIL abort_ptr: got gnt=%b, want 01", gnt);
        end
        req = 2'b00;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_stall;
        logic [3:0] pat;
        int idx;
        pat = 4'b1001;
        idx = 0;
        req = 2'b10; len1 = 4'd4; out_ready = 1'b0;
        @(negedge clk);
        for (int c = 0; c < 12 && idx < 4; c++) begin
            if (c > 0) @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_data !== fib[idx] || out_last !== (idx == 3)) begin
                errors++; $display("FAIL stall_cyc%0d: got v=%b d=%0d last=%b, want 1/%0d/%b",
                                   c, out_valid, out_data, out_last, fib[idx], (idx == 3));
            end
            out_ready = pat[c % 4];
            if (pat[c % 4]) begin
                if (idx == 3) req = 2'b00;
                idx++;
            end
        end
        checks++;
        if (idx != 4) begin
            errors++; $display("FAIL stall_timeout: got %0d beats, want 4", idx);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL stall_gap: got v=%b busy=%b, want 0/1", out_valid, busy);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        req = 2'b01; len0 = 4'd5; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) @(negedge clk);
        checks++;
        if (out_data !== fib[3]) begin
            errors++; $display("FAIL rmid_beat3: got d=%0d, want %0d", out_data, fib[3]);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({gnt, out_valid, out_data, out_id, out_last, ovf, busy} !== 14'd0) begin
            errors++; $display("FAIL rmid_async: got gnt=%b v=%b d=%0d id=%b last=%b ovf=%b busy=%b, want all 0",
                               gnt, out_valid, out_data, out_id, out_last, ovf, busy);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (gnt !== 2'b01 || out_valid !== 1'b1 || out_data !== 8'd0) begin
            errors++; $display("FAIL rmid_restart: got gnt=%b v=%b d=%0d, want 01/1/0", gnt, out_valid, out_data);
        end
        req = 2'b00;
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_tie();
        test_single();
        test_ovf();
        test_abort();
        test_stall();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fibo_sched.md
FIBO_SCHED -- requirements
Module: fibo_sched

Interface
REQ-001 SHALL have parameter DATA_W, default 8, term width.
REQ-002 SHALL have parameter CNT_W, default 4, sequence-length width.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req  input  2  per-requester sequence request, level; bit i = requester i.
REQ-006 SHALL have port len0  input  CNT_W  term count for requester 0; 0 means 2^CNT_W.
REQ-007 SHALL have port len1  input  CNT_W  term count for requester 1; 0 means 2^CNT_W.
REQ-008 SHALL have port gnt  output  2  one-hot grant; high for the whole sequence.
REQ-009 SHALL have port out_valid  output  1  term beat valid.
REQ-010 SHALL have port out_ready  input  1  sink accepts beat.
REQ-011 SHALL have port out_data  output  DATA_W  current Fibonacci term.
REQ-012 SHALL have port out_id  output  1  index of the granted requester.
REQ-013 SHALL have port out_last  output  1  final beat of the sequence.
REQ-014 SHALL have port ovf  output  1  saturation flag for the current sequence.
REQ-015 SHALL have port busy  output  1  high in RUN and GAP.

Function
REQ-016 SHALL implement FSM states: IDLE, RUN, GAP.
REQ-017 IDLE: if any req bit is high, SHALL, on that edge, select the winner, register gnt/out_id, latch the winner's len, load terms a=0 and b=1, and enter RUN.
REQ-018 Arbitration SHALL be round-robin with a 1-bit priority pointer: the pointer holder wins when both requests are high; a single requester always wins.
REQ-019 After each sequence ends (completion or abort), the pointer SHALL point to the requester not just served.
REQ-020 RUN: out_valid SHALL be 1 and out_data SHALL equal a; a beat transfers when out_valid and out_ready are both high.
REQ-021 On a transfer, SHALL update a<=b and b<=a+b, and decrement the remaining count.
REQ-022 While out_valid is high and out_ready is low, out_data, out_last and ovf SHALL hold stable.
REQ-023 Latency: req seen in IDLE at edge t SHALL give gnt and out_valid high with out_data=0 after edge t.
REQ-024 The sequence SHALL emit exactly len terms: 0,1,1,2,3,5,...
REQ-025 out_last SHALL be high only on the final beat; after its transfer the FSM SHALL enter GAP.
REQ-026 If a+b exceeds 2^DATA_W-1, b SHALL saturate to all-ones; any beat whose out_data is all-ones from saturation SHALL have ovf=1, and ovf SHALL stay set until the sequence ends.
REQ-027 If the granted requester drops its req in RUN, SHALL abort: enter GAP on the next edge, out_valid goes low, and no out_last is emitted.
REQ-028 A transfer and a req drop on the same edge SHALL count the beat, then abort.
REQ-029 GAP SHALL last exactly one cycle with gnt=0, out_valid=0 and ovf cleared, then enter IDLE.
REQ-030 out_valid SHALL be 0 in IDLE and GAP.

Reset
REQ-031 rst low SHALL asynchronously force IDLE, gnt=0, out_valid=0, out_data=0, out_id=0, out_last=0, ovf=0, busy=0, pointer=0, a=0, b=1, count=0.
REQ-032 Reset asserted mid-RUN SHALL discard the sequence; operation SHALL restart in IDLE on the first edge after release.

Structure
REQ-033 Shared package fibo_sched_pkg SHALL hold the state encoding and the DATA_W/CNT_W defaults.
REQ-034 SHALL instantiate one sub-module, fibo_core, holding a/b with load, step and saturation-flag logic; the arbiter, FSM and counter stay in fibo_sched.

Verification
REQ-035 req=01, len0=5, out_ready=1 -> gnt=01 one cycle later; data 0,1,1,2,3; out_last on 3; one GAP cycle; then IDLE.
REQ-036 Both req rise together after reset, len0=3, len1=2 -> id0 gets 0,1,1, GAP, then id1 gets 0,1; next tie goes to id0.
REQ-037 len0=0, DATA_W=8 -> 16 beats; beats 0-13 are 0..233 with ovf=0; beats 14,15 are 255 with ovf=1; ovf=0 in GAP.
REQ-038 out_ready toggles 1,0,0,1 during RUN -> out_data is held during stalls, no term is skipped or duplicated.
REQ-039 req1 drops after 2 transfers -> out_valid=0 next cycle, no out_last, GAP, pointer moves to 0.
REQ-040 rst low during beat 3 -> all outputs go to 0 immediately; req held after release -> new sequence starts at 0.
